// File: rtl/slave_i2c_pkg.sv
// slave_i2c_pkg: shared types and constants for the slave I2C transmit path
package slave_i2c_pkg;
   typedef enum logic [2:0] {IDLE, WAIT_DATA, LOAD, SHIFT, ACK} tx_state_t;
   localparam int BYTE_W = 8;
   localparam int BITCNT_W = 3;
   localparam logic [BITCNT_W-1:0] LAST_BIT = 3'd7;
endpackage

// File: rtl/slave_tx_hold_reg.sv
// slave_tx_hold_reg: one-byte holding register with valid/ready write and consume
module slave_tx_hold_reg
   import slave_i2c_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic              consume,
   output logic              full,
   output logic [BYTE_W-1:0] rd_data
);
   // consume only happens in LOAD, which requires full, so it never collides with a write
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         full <= 1'b0;
         rd_data <= '0;
      end else if (wr_valid && !full) begin
         full <= 1'b1;
         rd_data <= wr_data;
      end else if (consume) begin
         full <= 1'b0;
      end
   assign wr_ready = !full;
endmodule

// File: rtl/slave_tx_ctrl.sv
// slave_tx_ctrl: sequences byte load, MSB-first shift and master ACK/NACK for the slave
// read path, driving the downstream PISO and requesting SCL stretch while starved
module slave_tx_ctrl
   import slave_i2c_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              slave_scl_sixt,
   input  logic              slave_rst,
   input  logic              slave_tx_start,
   input  logic              slave_stop,
   input  logic [BYTE_W-1:0] slave_tx_byte,
   input  logic              slave_tx_valid,
   output logic              slave_tx_ready,
   output logic [BYTE_W-1:0] slave_data,
   output logic              slave_load_data,
   output logic              slave_shift_data,
   input  logic              slave_serial_out_data,
   input  logic              slave_sda_in,
   output logic              slave_sda_oe,
   output logic              slave_sda_out,
   output logic              slave_scl_hold,
   output logic [CNT_W-1:0]  slave_byte_count,
   output logic              slave_tx_done,
   output logic              slave_nack
);
   tx_state_t state, state_nxt;
   logic [BITCNT_W-1:0] bit_cnt;
   logic hold_full;

   slave_tx_hold_reg u_hold (
      .clk      (slave_scl_sixt),
      .rst      (slave_rst),
      .wr_data  (slave_tx_byte),
      .wr_valid (slave_tx_valid),
      .wr_ready (slave_tx_ready),
      .consume  (state == LOAD),
      .full     (hold_full),
      .rd_data  (slave_data)
   );

   always_ff @(posedge slave_scl_sixt or posedge slave_rst)
      if (slave_rst) begin
         state <= IDLE;
         bit_cnt <= '0;
         slave_byte_count <= '0;
         slave_nack <= 1'b0;
         slave_tx_done <= 1'b0;
      end else begin
         state <= state_nxt;
         bit_cnt <= (state == SHIFT) ? bit_cnt + 1'b1 : '0;
         slave_tx_done <= (state != IDLE) && (slave_stop || (state == ACK && slave_sda_in));
         if (state == IDLE && slave_tx_start && !slave_stop) begin
            slave_byte_count <= '0;
            slave_nack <= 1'b0;
         end else if (state == ACK && !slave_stop) begin
            slave_byte_count <= (slave_byte_count == '1) ? slave_byte_count : slave_byte_count + 1'b1;
            slave_nack <= slave_nack | slave_sda_in;
         end
      end

   always_comb begin
      state_nxt = state;
      slave_scl_hold = 1'b0;
      slave_load_data = 1'b0;
      slave_shift_data = 1'b0;
      slave_sda_oe = 1'b0;
      case (state)
         IDLE:      state_nxt = !slave_tx_start ? IDLE : hold_full ? LOAD : WAIT_DATA;
         WAIT_DATA: begin
            slave_scl_hold = 1'b1;
            state_nxt = hold_full ? LOAD : WAIT_DATA;
         end
         LOAD:      begin
            slave_load_data = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT:     begin
            slave_sda_oe = 1'b1;
            slave_shift_data = bit_cnt != LAST_BIT;
            state_nxt = (bit_cnt == LAST_BIT) ? ACK : SHIFT;
         end
         ACK:       state_nxt = slave_sda_in ? IDLE : hold_full ? LOAD : WAIT_DATA;
         default:   state_nxt = IDLE;
      endcase
      if (slave_stop)
         state_nxt = IDLE;
   end

   assign slave_sda_out = slave_sda_oe ? slave_serial_out_data : 1'b1;
endmodule

// File: tb/tb_slave_tx_ctrl.sv
// tb_slave_tx_ctrl: randomized master/register-file stimulus checked against a
// transaction-level model of byte order, bit order, ACK handling and counters
module tb_slave_tx_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic tx_start = 1'b0, tx_stop = 1'b0, tx_valid = 1'b0, sda_in = 1'b1;
   logic [7:0] tx_byte = '0;
   logic tx_ready, load_data, shift_data, sda_oe, sda_out, scl_hold, tx_done, nack;
   logic [7:0] data, byte_count, piso;
   int n_vec = 0, n_err = 0, cyc = 0, last_hs = 0;
   logic [7:0] feed_q[$], exp_q[$];
   int dly_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk or posedge rst)
      if (rst) piso <= '0;
      else if (load_data) piso <= data;
      else if (shift_data) piso <= {piso[6:0], 1'b0};

   slave_tx_ctrl #(.CNT_W(8)) dut (
      .slave_scl_sixt        (clk),
      .slave_rst             (rst),
      .slave_tx_start        (tx_start),
      .slave_stop            (tx_stop),
      .slave_tx_byte         (tx_byte),
      .slave_tx_valid        (tx_valid),
      .slave_tx_ready        (tx_ready),
      .slave_data            (data),
      .slave_load_data       (load_data),
      .slave_shift_data      (shift_data),
      .slave_serial_out_data (piso[7]),
      .slave_sda_in          (sda_in),
      .slave_sda_oe          (sda_oe),
      .slave_sda_out         (sda_out),
      .slave_scl_hold        (scl_hold),
      .slave_byte_count      (byte_count),
      .slave_tx_done         (tx_done),
      .slave_nack            (nack)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat(input int v);
      return v > 255 ? 255 : v;
   endfunction

   task automatic push(input logic [7:0] b, input int d);
      feed_q.push_back(b);
      dly_q.push_back(d);
      exp_q.push_back(b);
   endtask

   task automatic wait_full();
      for (int i = 0; i < 40 && tx_ready; i++) step();
      check("hold_fill", tx_ready, 0);
   endtask

   // register-file side: offers queued bytes after a per-byte delay
   initial begin
      logic [7:0] b;
      logic r;
      int d;
      forever begin
         if (feed_q.size() == 0 || rst) step();
         else begin
            b = feed_q.pop_front();
            d = dly_q.pop_front();
            repeat (d) step();
            tx_byte = b;
            tx_valid = 1'b1;
            do begin
               r = tx_ready;
               step();
            end while (!r);
            last_hs = cyc;
            tx_valid = 1'b0;
         end
      end
   end

   // master side: n bytes, ACK all but the last; abort 1 = STOP, 2 = reset at shift cycle abort_at
   task automatic run_txn(input int n, input int abort, input int abort_at);
      logic [7:0] b, got;
      int w, shifts;
      bit hold_ok, ok;
      tx_start = 1'b1;
      step();
      tx_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         b = exp_q.pop_front();
         w = 0;
         hold_ok = 1'b1;
         while (!load_data && w < 60) begin
            hold_ok &= scl_hold & !sda_oe;
            step();
            w++;
         end
         check("load_seen", load_data, 1);
         if (!load_data) return;
         check("wait_hold", hold_ok, 1);
         if (w > 0) check("load_latency", cyc - last_hs, 1);
         check("load_lines", {sda_oe, scl_hold, sda_out}, 3'b001);
         check("count_pre", byte_count, sat(i));
         got = '0;
         shifts = 0;
         ok = 1'b1;
         for (int k = 0; k < 8; k++) begin
            step();
            if (abort == 1 && k == abort_at) begin
               tx_stop = 1'b1;
               step();
               tx_stop = 1'b0;
               check("stop_lines", {sda_oe, load_data, scl_hold}, 0);
               check("stop_done", tx_done, 1);
               check("stop_count", byte_count, i);
               check("stop_nack", nack, 0);
               step();
               check("stop_done_pulse", {tx_done, load_data}, 0);
               return;
            end
            if (abort == 2 && k == abort_at) begin
               #2 rst = 1'b1;
               #1;
               check("rst_lines", {sda_oe, sda_out, load_data, shift_data, scl_hold, tx_done, nack}, 7'b0100000);
               check("rst_ready", tx_ready, 1);
               check("rst_data", data, 0);
               check("rst_count", byte_count, 0);
               step();
               rst = 1'b0;
               return;
            end
            ok &= sda_oe && (shift_data == (k != 7));
            got = {got[6:0], sda_out};
            shifts += int'(shift_data);
         end
         check("byte_bits", got, b);
         check("shift_count", shifts, 7);
         check("shift_lines", ok, 1);
         step();
         check("ack_release", {sda_oe, sda_out, load_data}, 3'b010);
         sda_in = (i == n - 1);
         step();
         sda_in = 1'b1;
         if (i == n - 1) begin
            check("end_done", tx_done, 1);
            check("end_nack", nack, 1);
            check("end_count", byte_count, sat(n));
            check("end_idle", {sda_oe, scl_hold, load_data}, 0);
            step();
            check("end_done_pulse", {tx_done, nack}, 2'b01);
         end else begin
            check("mid_done", {tx_done, nack}, 0);
         end
      end
   endtask

   initial begin
      logic [7:0] prev_cnt;
      #3;
      check("reset_lines", {sda_oe, sda_out, load_data, shift_data, scl_hold, tx_done, nack, tx_ready}, 8'b01000001);
      check("reset_regs", {data, byte_count}, 0);
      step();
      rst = 1'b0;
      step();
      push(8'hA5, 0);
      wait_full();
      push(8'h3C, 0);
      run_txn(2, 0, 0);
      push(8'hFF, 6);
      run_txn(1, 0, 0);
      push(8'hAA, 0);
      push(8'h01, 15);
      run_txn(2, 0, 0);
      push(8'h80, 0);
      wait_full();
      run_txn(1, 1, 4);
      push(8'h5A, 0);
      wait_full();
      prev_cnt = byte_count;
      tx_start = 1'b1;
      tx_stop = 1'b1;
      step();
      tx_start = 1'b0;
      tx_stop = 1'b0;
      check("startstop_idle", {load_data, scl_hold, sda_oe, tx_done}, 0);
      check("startstop_count", byte_count, prev_cnt);
      step();
      check("startstop_still", load_data, 0);
      run_txn(1, 0, 0);
      for (int t = 0; t < 10; t++) begin
         int n;
         n = $urandom_range(1, 4);
         for (int j = 0; j < n; j++) push(8'($urandom), $urandom_range(0, 14));
         run_txn(n, 0, 0);
      end
      for (int j = 0; j < 257; j++) push(8'($urandom), 0);
      run_txn(257, 0, 0);
      push(8'hC3, 0);
      run_txn(1, 2, 3);
      push(8'($urandom), $urandom_range(0, 10));
      push(8'($urandom), 0);
      run_txn(2, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/slave_tx_ctrl.md
Name: slave_tx_ctrl

Overview:
Slave read-path transmit controller. Sits directly upstream of the slave transmit PISO (slave_piso_data) and drives its slave_data, slave_load_data and slave_shift_data inputs. It accepts bytes from the slave register file through a valid/ready handshake into a one-byte holding register. It sequences load, 8 bit-times and master ACK/NACK, gates SDA, and requests SCL stretching when no byte is ready.

Parameters:
CNT_W, 8, width of transmitted-byte counter; saturates at all-ones.

Ports:
slave_scl_sixt  in  1  bit clock, shared with the PISO; this block uses the rising edge, the PISO samples its controls on the falling edge.
slave_rst  in  1  asynchronous, active-high reset.
slave_tx_start  in  1  pulse: slave addressed for read, address ACK complete.
slave_stop  in  1  pulse: STOP or repeated START detected.
slave_tx_byte  in  8  next byte from the register file.
slave_tx_valid  in  1  slave_tx_byte valid.
slave_tx_ready  out  1  holding register empty, so a byte can be accepted.
slave_data  out  8  holding register contents, to PISO slave_data.
slave_load_data  out  1  to PISO load.
slave_shift_data  out  1  to PISO shift.
slave_serial_out_data  in  1  PISO serial output (bit 7).
slave_sda_in  in  1  sampled SDA line, used for master ACK/NACK.
slave_sda_oe  out  1  1 = slave drives SDA.
slave_sda_out  out  1  SDA value when driven.
slave_scl_hold  out  1  clock-stretch request.
slave_byte_count  out  CNT_W  bytes ACKed or NACKed in the current transaction.
slave_tx_done  out  1  one-cycle pulse at transaction end.
slave_nack  out  1  sticky: the transaction ended on master NACK.

Behaviour:
- Reset (async, active-high) values:
  - all FSM outputs 0, slave_tx_ready=1, slave_sda_out=1, slave_data=8'h00, slave_byte_count=0, state IDLE, hold register empty.
- Holding register:
  - Write when slave_tx_valid & slave_tx_ready.
  - Emptied at the end of the LOAD cycle.
  - slave_tx_ready is registered and equals !hold_full, so a write and a consume never happen in the same cycle.
  - Contents are retained across STOP.
- FSM states: IDLE, WAIT_DATA, LOAD, SHIFT, ACK. All outputs are Moore outputs, decoded from registered state.
- IDLE:
  - On slave_tx_start: clear slave_byte_count and slave_nack, then go to LOAD if hold_full, else WAIT_DATA.
- WAIT_DATA:
  - slave_scl_hold=1, slave_sda_oe=0.
  - Go to LOAD the cycle after hold_full becomes 1.
- LOAD (exactly 1 cycle):
  - slave_load_data=1, slave_sda_oe=0.
  - The PISO captures slave_data on this cycle's falling edge. Go to SHIFT with bit_cnt=0.
- SHIFT (8 cycles, bit_cnt 0..7):
  - slave_sda_oe=1.
  - slave_shift_data=1 when bit_cnt!=7, and 0 when bit_cnt==7 so the PISO holds after the LSB.
  - At the rising edge that begins SHIFT cycle n, SDA carries byte[7-n], MSB first.
  - After bit_cnt==7, go to ACK.
- ACK (1 cycle):
  - slave_sda_oe=0, and slave_sda_in is sampled at the rising edge that ends the cycle.
  - slave_byte_count increments in both cases, saturating.
  - sda_in=0 (ACK): go to LOAD if hold_full, else WAIT_DATA.
  - sda_in=1 (NACK): set slave_nack, pulse slave_tx_done for 1 cycle, go to IDLE.
- slave_sda_out = slave_sda_oe ? slave_serial_out_data : 1 (combinational).
- slave_stop in any non-IDLE state:
  - Next state is IDLE and slave_tx_done pulses. slave_nack is unchanged and slave_byte_count holds.
  - A byte interrupted mid-SHIFT is not counted.
- Simultaneous events:
  - slave_stop wins over slave_tx_start.
  - slave_tx_start outside IDLE is ignored.
- Reset mid-transfer returns to IDLE immediately, releases SDA and SCL, and empties the holding register.

Decomposition:
- Package slave_i2c_pkg holds:
  - state enum: IDLE, WAIT_DATA, LOAD, SHIFT, ACK
  - BYTE_W=8
  - BITCNT_W=3
  - LAST_BIT=3'd7
- One natural sub-module: slave_tx_hold_reg (8-bit holding register with valid/ready, load and consume).
- The FSM, bit counter and byte counter live in the top module.

Test Plan:
- Preload byte 8'hA5, pulse tx_start, master ACKs then NACKs the second byte 8'h3C -> SDA carries 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; shift_data high for 7 of 8 cycles per byte; byte_count=2, nack=1, tx_done pulses once.
- tx_start with empty holding register -> WAIT_DATA, scl_hold=1 until tx_valid with 8'hFF, then LOAD one cycle later; scl_hold drops, 8 ones on SDA.
- ACK with empty holding register -> scl_hold=1 after ACK; supplying 8'h01 resumes with LOAD and SDA 0,0,0,0,0,0,0,1.
- slave_stop in SHIFT bit_cnt=4 of byte 8'h80 -> IDLE next cycle, sda_oe=0, tx_done pulse, byte_count unchanged, nack=0.
- Async reset asserted mid-SHIFT (between clock edges) -> all outputs at reset values immediately; tx_ready=1.
- tx_start and stop in the same cycle while IDLE -> remains IDLE, no load_data, byte_count not cleared.
